// File: rtl/uart_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// uart_cmd_sequencer
//
// Frame-level command controller between a UART receiver and the board LEDs.
// It collects 4-byte frames {SYNC, CMD, ARG, CHK}, checks them, and updates
// the LED pattern. The pattern is either static or blinking. Each frame is
// answered with an ACK or NAK byte through a start/busy transmitter handshake.
//
// Ports:
//   clk_i        system clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   rx_data_i    received byte, valid while rx_valid_i is high
//   rx_valid_i   one-cycle strobe marking a new received byte
//   tx_busy_i    transmitter busy; rises the cycle after tx_start_o is accepted
//   tx_start_o   send request level, held until tx_busy_i is seen high
//   tx_data_o    reply byte, stable while tx_start_o is high
//   led_cmd_o    registered LED drive pattern
//   frame_err_o  one-cycle pulse when a frame times out between bytes
// -----------------------------------------------------------------------------
module uart_cmd_sequencer #(
    parameter logic [7:0] SYNC_BYTE   = 8'hAA,
    parameter logic [7:0] ACK_BYTE    = 8'h06,
    parameter logic [7:0] NAK_BYTE    = 8'h15,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter int         BLINK_UNIT  = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       tx_busy_i,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    output logic [3:0] led_cmd_o,
    output logic       frame_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int UW = (BLINK_UNIT > 1) ? $clog2(BLINK_UNIT) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [UW-1:0] UNIT_LAST = UW'(BLINK_UNIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_CMD,
        S_GET_ARG,
        S_GET_CHK,
        S_EXEC,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    arg_q, arg_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    pattern_q, pattern_d;
    logic          blink_q, blink_d;
    logic [7:0]    period_q, period_d;
    logic [UW-1:0] unit_q, unit_d;
    logic [7:0]    tick_q, tick_d;
    logic          phase_q, phase_d;
    logic [3:0]    led_q, led_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          frame_err_q, frame_err_d;

    logic          chk_ok;
    logic          cmd_static;
    logic          cmd_blink;
    logic          frame_ok;

    // Static LED patterns selected by the low bits of CMD 0x80..0x85.
    function automatic logic [3:0] static_pattern(input logic [2:0] sel);
        case (sel)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0100;
            3'd4:    return 4'b1000;
            3'd5:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Frame validation. It only matters in EXEC, where the three latched bytes are complete.
    // A blink command with ARG 0 would have no period, so it is rejected.
    assign chk_ok     = (chk_q == (cmd_q ^ arg_q));
    assign cmd_static = (cmd_q >= 8'h80) && (cmd_q <= 8'h85);
    assign cmd_blink  = (cmd_q == 8'h86) && (arg_q != 8'h00);
    assign frame_ok   = chk_ok && (cmd_static || cmd_blink);

    // Next-state logic. The blink counters run in every state.
    // EXEC is the only place that overwrites the LED configuration, and it takes
    // precedence over the free-running blink update in that cycle.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        chk_d       = chk_q;
        tmo_d       = tmo_q;
        pattern_d   = pattern_q;
        blink_d     = blink_q;
        period_d    = period_q;
        unit_d      = unit_q;
        tick_d      = tick_q;
        phase_d     = phase_q;
        tx_start_d  = tx_start_q;
        tx_data_d   = tx_data_q;
        frame_err_d = 1'b0;

        // The phase flips when the unit and tick counters wrap together.
        if (blink_q) begin
            if (unit_q == UNIT_LAST) begin
                unit_d = '0;
                if (tick_q == (period_q - 8'd1)) begin
                    tick_d  = 8'd0;
                    phase_d = ~phase_q;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end else begin
                unit_d = unit_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
                    state_d = S_GET_CMD;
                    tmo_d   = '0;
                end
            end

            // Inside a frame every byte is data, including one equal to SYNC_BYTE.
            S_GET_CMD, S_GET_ARG, S_GET_CHK: begin
                if (rx_valid_i) begin
                    tmo_d = '0;
                    case (state_q)
                        S_GET_CMD: begin
                            cmd_d   = rx_data_i;
                            state_d = S_GET_ARG;
                        end
                        S_GET_ARG: begin
                            arg_d   = rx_data_i;
                            state_d = S_GET_CHK;
                        end
                        default: begin
                            chk_d   = rx_data_i;
                            state_d = S_EXEC;
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            // If the transmitter is still busy, the request waits in SEND until busy drops.
            S_EXEC: begin
                if (frame_ok) begin
                    if (cmd_static) begin
                        pattern_d = static_pattern(cmd_q[2:0]);
                        blink_d   = 1'b0;
                        unit_d    = '0;
                        tick_d    = 8'd0;
                        phase_d   = 1'b0;
                    end else begin
                        blink_d  = 1'b1;
                        period_d = arg_q;
                        unit_d   = '0;
                        tick_d   = 8'd0;
                        phase_d  = 1'b1;
                    end
                    tx_data_d = ACK_BYTE;
                end else begin
                    tx_data_d = NAK_BYTE;
                end
                tx_start_d = ~tx_busy_i;
                state_d    = S_SEND;
            end

            S_SEND: begin
                if (!tx_start_q) begin
                    if (!tx_busy_i) begin
                        tx_start_d = 1'b1;
                    end
                end else if (tx_busy_i) begin
                    tx_start_d = 1'b0;
                    state_d    = S_WAIT_TX;
                end
            end

            S_WAIT_TX: begin
                if (!tx_busy_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The LED register is built from the next configuration, so a new command shows one edge after EXEC.
        if (blink_d) begin
            led_d = phase_d ? pattern_d : 4'b0000;
        end else begin
            led_d = pattern_d;
        end
    end

    // State register. Reset clears everything and drops any frame or reply in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'h00;
            arg_q       <= 8'h00;
            chk_q       <= 8'h00;
            tmo_q       <= '0;
            pattern_q   <= 4'b0000;
            blink_q     <= 1'b0;
            period_q    <= 8'h00;
            unit_q      <= '0;
            tick_q      <= 8'h00;
            phase_q     <= 1'b0;
            led_q       <= 4'b0000;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            pattern_q   <= pattern_d;
            blink_q     <= blink_d;
            period_q    <= period_d;
            unit_q      <= unit_d;
            tick_q      <= tick_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign tx_start_o  = tx_start_q;
    assign tx_data_o   = tx_data_q;
    assign led_cmd_o   = led_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_sequencer
//
// Directed bench for uart_cmd_sequencer. It uses a short timeout and blink unit
// so that the multi-cycle behaviour fits in a short run.
// -----------------------------------------------------------------------------
module tb_uart_cmd_sequencer;

    localparam int         TMO  = 16;
    localparam int         UNIT = 4;
    localparam logic [7:0] SYNC = 8'hAA;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] led_cmd;
    logic       frame_err;

    int errors;
    int checks;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] arg;
        logic [7:0] chk;
        logic [3:0] expLed;
        logic [7:0] expTx;
    } vec_t;

    vec_t vecs[11];

    uart_cmd_sequencer #(
        .SYNC_BYTE  (SYNC),
        .ACK_BYTE   (ACK),
        .NAK_BYTE   (NAK),
        .TIMEOUT_CYC(TMO),
        .BLINK_UNIT (UNIT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .tx_busy_i  (tx_busy),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .led_cmd_o  (led_cmd),
        .frame_err_o(frame_err)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step to one time unit after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one received byte for a single cycle.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Send a full frame and check the outputs one edge after the CHK byte is taken.
    task automatic sendFrame(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk,
                             input logic [3:0] expLed, input logic [7:0] expTx,
                             input logic expStart, input string tag);
        applyStimulus(SYNC);
        applyStimulus(cmd);
        applyStimulus(arg);
        applyStimulus(chk);
        checkOutput({tag, "_startLatency"}, {7'd0, tx_start}, 8'h00);
        tick();
        checkOutput({tag, "_led"}, {4'd0, led_cmd}, {4'd0, expLed});
        checkOutput({tag, "_txData"}, tx_data, expTx);
        checkOutput({tag, "_txStart"}, {7'd0, tx_start}, {7'd0, expStart});
    endtask

    // Act as the transmitter: accept the request, then go idle again.
    task automatic finishReply(input string tag);
        tx_busy = 1'b1;
        tick();
        checkOutput({tag, "_startDrop"}, {7'd0, tx_start}, 8'h00);
        tx_busy = 1'b0;
        tick();
    endtask

    initial begin
        int errCount;
        int errAt;
        int badCount;
        logic startSeen;

        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;

        // The LED column carries the state left by the earlier rows. A NAK row keeps the previous LEDs.
        vecs[0]  = '{8'h83, 8'h11, 8'h92, 4'b0100, ACK};
        vecs[1]  = '{8'h81, 8'h00, 8'h80, 4'b0100, NAK};
        vecs[2]  = '{8'h90, 8'h00, 8'h90, 4'b0100, NAK};
        vecs[3]  = '{8'h84, 8'h00, 8'h84, 4'b1000, ACK};
        vecs[4]  = '{8'h86, 8'h00, 8'h86, 4'b1000, NAK};
        vecs[5]  = '{8'h81, 8'h5A, 8'hDB, 4'b0001, ACK};
        vecs[6]  = '{8'h85, 8'h00, 8'h85, 4'b1111, ACK};
        vecs[7]  = '{8'h80, 8'hAA, 8'h2A, 4'b0000, ACK};
        vecs[8]  = '{8'h82, 8'h01, 8'h83, 4'b0010, ACK};
        vecs[9]  = '{8'h87, 8'h00, 8'h87, 4'b0010, NAK};
        vecs[10] = '{8'h7F, 8'h00, 8'h7F, 4'b0010, NAK};

        tick();
        tick();
        checkOutput("rst_led", {4'd0, led_cmd}, 8'h00);
        checkOutput("rst_txStart", {7'd0, tx_start}, 8'h00);
        checkOutput("rst_txData", tx_data, 8'h00);
        checkOutput("rst_frameErr", {7'd0, frame_err}, 8'h00);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            sendFrame(vecs[i].cmd, vecs[i].arg, vecs[i].chk, vecs[i].expLed, vecs[i].expTx,
                      1'b1, $sformatf("vec%0d", i));
            finishReply($sformatf("vec%0d", i));
        end

        // Blink 1111 with ARG 2 and unit 4: eight cycles on, then eight cycles off.
        sendFrame(8'h85, 8'h00, 8'h85, 4'b1111, ACK, 1'b1, "blinkPat");
        finishReply("blinkPat");
        sendFrame(8'h86, 8'h02, 8'h84, 4'b1111, ACK, 1'b1, "blinkOn");
        for (int k = 1; k < 24; k++) begin
            if (k == 1) tx_busy = 1'b1;
            if (k == 2) tx_busy = 1'b0;
            tick();
            checkOutput($sformatf("blink%0d", k), {4'd0, led_cmd},
                        (((k / 8) % 2) == 0) ? 8'h0F : 8'h00);
        end
        sendFrame(8'h80, 8'h00, 8'h80, 4'b0000, ACK, 1'b1, "blinkOff");
        finishReply("blinkOff");
        sendFrame(8'h84, 8'h00, 8'h84, 4'b1000, ACK, 1'b1, "static");
        finishReply("static");
        badCount = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (led_cmd !== 4'b1000) badCount++;
        end
        checkOutput("staticHold", 8'(badCount), 8'h00);

        // Inter-byte timeout after SYNC and CMD.
        applyStimulus(SYNC);
        applyStimulus(8'h82);
        errCount  = 0;
        errAt     = -1;
        startSeen = 1'b0;
        for (int k = 1; k <= TMO + 4; k++) begin
            tick();
            if (frame_err === 1'b1) begin
                errCount++;
                if (errAt < 0) errAt = k;
            end
            if (tx_start === 1'b1) startSeen = 1'b1;
        end
        checkOutput("tmoPulses", 8'(errCount), 8'h01);
        checkOutput("tmoNoReply", {7'd0, startSeen}, 8'h00);
        checkOutput("tmoWindow", {7'd0, (errAt == TMO - 1) || (errAt == TMO)}, 8'h01);
        sendFrame(8'h84, 8'h00, 8'h84, 4'b1000, ACK, 1'b1, "afterTmo");
        finishReply("afterTmo");

        // Transmitter busy at EXEC holds off the request. Bytes sent meanwhile are dropped.
        tx_busy = 1'b1;
        sendFrame(8'h83, 8'h11, 8'h92, 4'b0100, ACK, 1'b0, "hold");
        applyStimulus(SYNC);
        applyStimulus(8'h85);
        applyStimulus(8'h00);
        applyStimulus(8'h85);
        checkOutput("holdOff", {7'd0, tx_start}, 8'h00);
        tx_busy = 1'b0;
        tick();
        checkOutput("holdRelease", {7'd0, tx_start}, 8'h01);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("holdStart%0d", k), {7'd0, tx_start}, 8'h01);
            checkOutput($sformatf("holdData%0d", k), tx_data, ACK);
        end
        finishReply("hold");
        checkOutput("dropLed", {4'd0, led_cmd}, 8'h04);
        applyStimulus(8'h55);
        sendFrame(8'h82, 8'h01, 8'h83, 4'b0010, ACK, 1'b1, "stray");
        finishReply("stray");

        // Reset in GET_ARG, then reset in SEND.
        applyStimulus(SYNC);
        applyStimulus(8'h86);
        rst = 1'b1;
        tick();
        checkOutput("rstArg_led", {4'd0, led_cmd}, 8'h00);
        checkOutput("rstArg_txStart", {7'd0, tx_start}, 8'h00);
        checkOutput("rstArg_txData", tx_data, 8'h00);
        checkOutput("rstArg_frameErr", {7'd0, frame_err}, 8'h00);
        rst = 1'b0;
        sendFrame(8'h83, 8'h11, 8'h92, 4'b0100, ACK, 1'b1, "postRst1");
        rst = 1'b1;
        tick();
        checkOutput("rstSend_txStart", {7'd0, tx_start}, 8'h00);
        checkOutput("rstSend_txData", tx_data, 8'h00);
        checkOutput("rstSend_led", {4'd0, led_cmd}, 8'h00);
        rst = 1'b0;
        sendFrame(8'h81, 8'h00, 8'h81, 4'b0001, ACK, 1'b1, "postRst2");
        finishReply("postRst2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
